gru_seq_frontend: RTL and testbench

- Sequence front end that sits directly upstream of gru_cell_parallel.
- Accepts a serial valid/ready stream of fixed-point samples and packs every D samples into a ping-pong x_t vector bank.
- Launches the cell with a one-cycle start pulse and feeds the returned h_t back as h_t_prev for the next timestep.
- At end of sequence, presents the final hidden state on a valid/ready output and clears the recurrent state.

---
 rtl/gru_pkg.sv | 27 ++
 rtl/gru_vec_pingpong.sv | 83 ++++++++
 rtl/gru_seq_frontend.sv | 133 +++++++++++++
 tb/tb_gru_seq_frontend.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gru_pkg.sv
// gru_pkg: types and dimensions shared by the GRU sequence front end and
// the cell it drives.
//   D          input features per timestep (samples per bank)
//   H          hidden units
//   DATA_WIDTH signed fixed-point sample width
//   FRAC_BITS  fractional bits of a sample (format only; no arithmetic here)
//   STEP_W     width of the optional timestep counter
package gru_pkg;

  localparam int D          = 64;
  localparam int H          = 16;
  localparam int DATA_WIDTH = 15;
  localparam int FRAC_BITS  = 9;
  localparam int STEP_W     = 12;
  localparam int IDX_W      = $clog2(D);

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef data_t [D-1:0]                xvec_t;
  typedef data_t [H-1:0]                hvec_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    OUT
  } fe_state_t;

endpackage

// File: rtl/gru_vec_pingpong.sv
// gru_vec_pingpong: two D-entry sample banks used ping-pong style. The
// serial input stream fills the bank selected by fill_sel; the bank selected
// by rd_sel is presented to the cell. A bank becomes full after D accepts and
// stays full (blocking further writes to it) until the consumer releases it.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   in_valid      sample valid
//   in_ready      bank under fill has space
//   in_data       sample
//   in_last       end-of-sequence marker, captured only with sample D-1
//   rd_release    consumer is done with the read bank: free it and advance
//   rd_full       read bank holds a complete vector
//   rd_last       read bank holds the final timestep of a sequence
//   rd_vec        read bank contents (zero while the read bank is not full)
module gru_vec_pingpong
  import gru_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  data_t in_data,
  input  logic  in_last,
  input  logic  rd_release,
  output logic  rd_full,
  output logic  rd_last,
  output xvec_t rd_vec
);

  xvec_t            bank [2];
  logic [1:0]       full;
  logic [1:0]       last;
  logic [IDX_W-1:0] wr_idx;
  logic             fill_sel;
  logic             rd_sel;
  logic             accept;
  logic             bank_done;

  assign in_ready  = !full[fill_sel];
  assign accept    = in_valid && in_ready;
  assign bank_done = accept && (wr_idx == IDX_W'(D - 1));

  // NOTE: sample storage is deliberately left out of reset; a bank is only
  // ever observed through rd_vec, which is masked to zero until its full flag
  // is set, so stale contents after reset are never visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[fill_sel][wr_idx] <= in_data;
    end
  end

  // NOTE: every register in an always_ff is assigned with <= so all state
  // updates of one edge see the pre-edge values of each other.
  // The bank finishing its fill is never the bank being released: a release
  // needs the read bank full, and a full bank cannot accept samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      full     <= '0;
      last     <= '0;
    end else begin
      if (accept) begin
        wr_idx <= bank_done ? '0 : wr_idx + 1'b1;
      end
      if (bank_done) begin
        full[fill_sel] <= 1'b1;
        last[fill_sel] <= in_last;
        fill_sel       <= !fill_sel;
      end
      if (rd_release) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
    end
  end

  assign rd_full = full[rd_sel];
  assign rd_last = last[rd_sel];
  assign rd_vec  = full[rd_sel] ? bank[rd_sel] : '0;

endmodule

// File: rtl/gru_seq_frontend.sv
// gru_seq_frontend: sequence front end for gru_cell_parallel. Packs the
// serial sample stream into x_t vectors, launches the cell once per
// timestep, feeds each returned h_t back as h_t_prev, and hands the final
// hidden state of a sequence to the consumer before clearing the state.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (shared with cell)
//   in_valid/in_ready    sample stream handshake
//   in_data, in_last     sample and end-of-sequence marker (index D-1 only)
//   x_t, h_t_prev        operands to the cell, stable while it computes
//   cell_start           one-cycle launch pulse
//   cell_done, cell_h_t  one-cycle completion pulse and result from the cell
//   out_valid/out_ready  final hidden state handshake
//   out_h                final hidden state of the sequence
//   step_count           completed timesteps in the current sequence
// Build option: define GRU_FE_STEPCNT_EN to build the saturating timestep
// counter; otherwise step_count is tied to zero.
module gru_seq_frontend
  import gru_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  data_t             in_data,
  input  logic              in_last,
  output xvec_t             x_t,
  output hvec_t             h_t_prev,
  output logic              cell_start,
  input  logic              cell_done,
  input  hvec_t             cell_h_t,
  output logic              out_valid,
  input  logic              out_ready,
  output hvec_t             out_h,
  output logic [STEP_W-1:0] step_count
);

  fe_state_t state;
  fe_state_t state_nxt;
  hvec_t     h_prev;
  hvec_t     out_h_q;
  logic      rd_full;
  logic      rd_last;
  logic      step_done;
  logic      out_fire;

  gru_vec_pingpong u_pingpong (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .rd_release (step_done),
    .rd_full    (rd_full),
    .rd_last    (rd_last),
    .rd_vec     (x_t)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    cell_start = 1'b0;
    out_valid  = 1'b0;
    step_done  = 1'b0;
    out_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_full) begin
          cell_start = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        // cell_done is only meaningful here; pulses in other states are dropped.
        if (cell_done) begin
          step_done = 1'b1;
          state_nxt = rd_last ? OUT : IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_last is sampled before the read bank is released in the same edge,
  // so it still describes the timestep that just completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      h_prev  <= '0;
      out_h_q <= '0;
    end else begin
      state <= state_nxt;
      if (step_done) begin
        h_prev <= cell_h_t;
        if (rd_last) begin
          out_h_q <= cell_h_t;
        end
      end else if (out_fire) begin
        h_prev <= '0;
      end
    end
  end

  assign h_t_prev = h_prev;
  assign out_h    = out_h_q;

`ifdef GRU_FE_STEPCNT_EN
  logic [STEP_W-1:0] step_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q <= '0;
    end else if (out_fire) begin
      step_q <= '0;
    end else if (step_done && (step_q != '1)) begin
      step_q <= step_q + 1'b1;
    end
  end

  assign step_count = step_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_gru_seq_frontend.sv
// tb_gru_seq_frontend: scoreboard bench for gru_seq_frontend. The bench
// plays both the sample source and the GRU cell. Accepted samples and the
// captured end-of-sequence flags are queued and compared against x_t on every
// cell_start; the modelled recurrent state is compared against h_t_prev; each
// final cell result is queued and compared against out_h when out_valid rises.
module tb_gru_seq_frontend;
  import gru_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  data_t             in_data = '0;
  logic              in_last = 1'b0;
  xvec_t             x_t;
  hvec_t             h_t_prev;
  logic              cell_start;
  logic              cell_done = 1'b0;
  hvec_t             cell_h_t = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  hvec_t             out_h;
  logic [STEP_W-1:0] step_count;

  always #5 clk = ~clk;

  gru_seq_frontend dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .x_t        (x_t),
    .h_t_prev   (h_t_prev),
    .cell_start (cell_start),
    .cell_done  (cell_done),
    .cell_h_t   (cell_h_t),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_h      (out_h),
    .step_count (step_count)
  );

  typedef struct { data_t data; logic last; } samp_t;
  typedef struct { hvec_t h; int step; } out_t;

  localparam int K_ACC   = 0;
  localparam int K_START = 1;
  localparam int K_DONE  = 2;
  localparam int K_OUT   = 3;

  samp_t src_q[$];
  data_t exp_samp[$];
  logic  exp_last[$];
  hvec_t resp_q[$];
  out_t  out_q[$];

  int    n_total = 0;
  int    n_bad = 0;
  int    cyc = 0;

  hvec_t h_model = '0;
  int    step_model = 0;
  logic  busy_model = 1'b0;
  logic  cur_last = 1'b0;
  logic  hold_done = 1'b0;
  logic  spur_done = 1'b0;
  logic  out_rdy_en = 1'b0;
  logic  will_accept = 1'b0;
  logic  will_out = 1'b0;
  logic  prev_start = 1'b0;
  logic  out_seen = 1'b0;
  int    lat = 10;
  int    done_at = 0;
  int    bank_cnt = 0;
  int    acc_cnt = 0;
  int    start_cnt = 0;
  int    done_cnt = 0;
  int    outs_cnt = 0;
  int    last_fill_cyc = 0;
  int    last_start_cyc = 0;
  int    last_done_cyc = 0;
  int    last_acc_cyc = 0;
  samp_t cur_s;
  data_t cur_d;
  hvec_t cur_h;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic hvec_t fill_h(input int v);
    hvec_t r;
    for (int i = 0; i < H; i++) r[i] = data_t'(v);
    return r;
  endfunction

  function automatic int exp_step(input int s);
`ifdef GRU_FE_STEPCNT_EN
    return s;
`else
    return 0;
`endif
  endfunction

  function automatic int ev_count(input int kind);
    case (kind)
      K_ACC:   return acc_cnt;
      K_START: return start_cnt;
      K_DONE:  return done_cnt;
      default: return outs_cnt;
    endcase
  endfunction

  // Everything observed or driven on the DUT happens here, on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_valid    = 1'b0;
      in_last     = 1'b0;
      cell_done   = 1'b0;
      out_ready   = 1'b0;
      will_accept = 1'b0;
      will_out    = 1'b0;
      prev_start  = 1'b0;
    end else begin
      // Commit the sample handshake of the edge just passed.
      if (will_accept) begin
        cur_s = src_q.pop_front();
        exp_samp.push_back(cur_s.data);
        acc_cnt++;
        last_acc_cyc = cyc - 1;
        bank_cnt++;
        if (bank_cnt == D) begin
          bank_cnt = 0;
          exp_last.push_back(cur_s.last);
          last_fill_cyc = cyc - 1;
        end
      end
      // Commit the output handshake: the recurrent state restarts at zero.
      if (will_out) begin
        void'(out_q.pop_front());
        out_seen   = 1'b0;
        h_model    = '0;
        step_model = 0;
        outs_cnt++;
      end
      // Cell launch: check operands and schedule the completion.
      if (cell_start) begin
        check("start_pulse", prev_start, 1'b0);
        check("start_while_busy", busy_model, 1'b0);
        if (exp_samp.size() < D || exp_last.size() == 0) begin
          check("start_data_avail", 1'b0, 1'b1);
        end else begin
          for (int i = 0; i < D; i++) begin
            cur_d = exp_samp.pop_front();
            check($sformatf("x_t[%0d]", i), x_t[i], cur_d);
          end
          cur_last = exp_last.pop_front();
        end
        check("h_t_prev", h_t_prev, h_model);
        busy_model     = 1'b1;
        done_at        = cyc + lat;
        start_cnt++;
        last_start_cyc = cyc;
      end
      prev_start = cell_start;
      // Cell completion (or a stray pulse while the front end is idle).
      cell_done = 1'b0;
      if (busy_model && !hold_done && cyc >= done_at) begin
        cur_h = (resp_q.size() > 0) ? resp_q.pop_front() : fill_h(1);
        cell_done  = 1'b1;
        cell_h_t   = cur_h;
        h_model    = cur_h;
        if (step_model < 4095) step_model++;
        busy_model = 1'b0;
        last_done_cyc = cyc;
        done_cnt++;
        if (cur_last) out_q.push_back('{h: cur_h, step: step_model});
      end else if (spur_done) begin
        cell_done = 1'b1;
        cell_h_t  = fill_h(9);
        spur_done = 1'b0;
      end
      // Final hidden state.
      out_ready = out_rdy_en;
      will_out  = 1'b0;
      if (out_valid) begin
        if (out_q.size() == 0) begin
          check("out_expected", 1'b0, 1'b1);
        end else begin
          if (!out_seen) begin
            check("out_h", out_h, out_q[0].h);
            check("out_step", step_count, exp_step(out_q[0].step));
            out_seen = 1'b1;
          end
          will_out = out_ready;
        end
      end
      // Sample source.
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0].data;
        in_last  = src_q[0].last;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      will_accept = in_valid && in_ready;
    end
  end

  task automatic push_step(input int base, input int last_idx);
    for (int i = 0; i < D; i++) src_q.push_back('{data: data_t'(base + i), last: (i == last_idx)});
  endtask

  task automatic wait_ev(input string tag, input int kind, input int target);
    int  got;
    bit  hit;
    hit = 1'b0;
    got = ev_count(kind);
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk);
      got = ev_count(kind);
      if (got >= target) hit = 1'b1;
    end
    if (!hit) check({"timeout_", tag}, got, target);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_cell_start"}, cell_start, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_x_t_zero"}, (x_t == '0), 1'b1);
    check({tag, "_h_t_prev"}, h_t_prev, 0);
    check({tag, "_out_h"}, out_h, 0);
    check({tag, "_step_count"}, step_count, 0);
  endtask

  int a0;
  int d0;
  int s0;
  int o0;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    check_reset_outputs("rst");

    // Single step: samples 1..64, final timestep, cell returns all 5.
    lat = 10;
    out_rdy_en = 1'b1;
    resp_q.push_back(fill_h(5));
    push_step(1, 63);
    wait_ev("t1_start", K_START, 1);
    check("t1_start_lat", last_start_cyc - last_fill_cyc, 1);
    wait_ev("t1_out", K_OUT, 1);
    repeat (2) @(posedge clk);
    settle();
    check("t1_h_prev_clr", h_t_prev, 0);

    // Two-step sequence, output held until the consumer is ready.
    out_rdy_en = 1'b0;
    resp_q.push_back(fill_h(7));
    resp_q.push_back(fill_h(-3));
    push_step(100, -1);
    push_step(-200, 63);
    wait_ev("t2_start2", K_START, 3);
    settle();
    check("t2_h_prev_fb", h_t_prev, fill_h(7));
    wait_ev("t2_done2", K_DONE, 3);
    repeat (4) @(posedge clk);
    settle();
    check("t2_out_hold_valid", out_valid, 1'b1);
    check("t2_out_hold_h", out_h, fill_h(-3));
    check("t2_out_step", step_count, exp_step(2));
    out_rdy_en = 1'b1;
    wait_ev("t2_out", K_OUT, 2);

    // Backpressure: completion withheld while three timesteps are offered.
    hold_done = 1'b1;
    lat = 5;
    a0 = acc_cnt;
    push_step(1000, -1);
    push_step(2000, -1);
    push_step(3000, 63);
    wait_ev("t3_fill", K_ACC, a0 + 128);
    repeat (20) @(posedge clk);
    settle();
    check("t3_acc_stall", acc_cnt - a0, 128);
    check("t3_in_ready", in_ready, 1'b0);
    d0 = done_cnt;
    hold_done = 1'b0;
    wait_ev("t3_done", K_DONE, d0 + 1);
    wait_ev("t3_resume", K_ACC, a0 + 129);
    check("t3_resume_lat", last_acc_cyc - last_done_cyc, 1);
    wait_ev("t3_out", K_OUT, 3);

    // Bank 1 completes fill in the same cycle bank 0 completes compute.
    lat = 63;
    s0 = start_cnt;
    push_step(4000, -1);
    push_step(-4000, 63);
    wait_ev("t4_start", K_START, s0 + 2);
    check("t4_fill_eq_done", last_fill_cyc, last_done_cyc);
    check("t4_start_lat", last_start_cyc - last_done_cyc, 1);
    wait_ev("t4_out", K_OUT, 4);

    // Stray cell_done while idle, then in_last on a non-final index.
    lat = 10;
    settle();
    spur_done = 1'b1;
    repeat (3) @(posedge clk);
    settle();
    check("t5_no_start", cell_start, 1'b0);
    check("t5_no_out", out_valid, 1'b0);
    check("t5_h_keep", h_t_prev, h_model);
    check("t5_step_keep", step_count, exp_step(0));
    check("t5_in_ready", in_ready, 1'b1);
    d0 = done_cnt;
    resp_q.push_back(fill_h(2));
    resp_q.push_back(fill_h(-1));
    push_step(5000, 10);
    push_step(6000, 63);
    wait_ev("t5_done1", K_DONE, d0 + 1);
    repeat (2) @(posedge clk);
    settle();
    check("t5_last_ignored", out_valid, 1'b0);
    wait_ev("t5_out", K_OUT, 5);

    // Reset while the cell is busy, then a fresh timestep.
    hold_done = 1'b1;
    s0 = start_cnt;
    push_step(7000, 63);
    wait_ev("t6_start", K_START, s0 + 1);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2;
    src_q.delete();
    exp_samp.delete();
    exp_last.delete();
    resp_q.delete();
    out_q.delete();
    bank_cnt   = 0;
    busy_model = 1'b0;
    h_model    = '0;
    step_model = 0;
    out_seen   = 1'b0;
    hold_done  = 1'b0;
    rst_n      = 1'b1;
    settle();
    check_reset_outputs("t6_rst");
    o0 = outs_cnt;
    resp_q.push_back(fill_h(11));
    push_step(-100, 63);
    wait_ev("t6_out", K_OUT, o0 + 1);

    repeat (3) @(posedge clk);
    check("end_samples_consumed", exp_samp.size(), 0);
    check("end_outs_consumed", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
